// File: rtl/i2c_apb_cmd_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2c_apb_cmd_sequencer
// Description : APB master that runs one-byte I2C register write/read commands
//               through a COREI2C channel, paced by the core's SI interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_apb_cmd_sequencer #(
    parameter int unsigned CHANNEL        = 0,
    parameter logic [2:0]  CR_BITS        = 3'b000,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic       rsp_err,
    output logic [7:0] rsp_status,
    output logic [7:0] rsp_rdata,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [8:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       INT
);

    localparam logic [3:0]  c_CHAN       = 4'(CHANNEL);
    localparam logic [15:0] c_TO_LAST    = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]  c_ADDR_CTRL  = 5'h00;
    localparam logic [4:0]  c_ADDR_STAT  = 5'h04;
    localparam logic [4:0]  c_ADDR_DATA  = 5'h08;
    localparam logic [7:0]  c_ST_TIMEOUT = 8'hFF;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_APB_SETUP  = 4'd1,
        S_APB_ACCESS = 4'd2,
        S_GAP        = 4'd3,
        S_WAIT_INT   = 4'd4,
        S_CHECK      = 4'd5,
        S_ABORT      = 4'd6,
        S_DONE       = 4'd7
    } state_t;

    // Which APB transfer the shared SETUP/ACCESS states are carrying out.
    typedef enum logic [2:0] {
        OP_DATA   = 3'd0,
        OP_CTRL   = 3'd1,
        OP_STATUS = 3'd2,
        OP_RDATA  = 3'd3,
        OP_STOP   = 3'd4
    } op_t;

    state_t      r_state, w_state_nxt;
    op_t         r_op, w_op_nxt;
    logic [2:0]  r_step, w_step_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        r_err, w_err_nxt;
    logic [7:0]  r_status, w_status_nxt;
    logic [7:0]  r_rdata, w_rdata_nxt;
    logic        w_load_cmd;
    logic        r_rd;
    logic [6:0]  r_dev;
    logic [7:0]  r_reg;
    logic [7:0]  r_wdata;
    logic        r_rsp_err;
    logic [7:0]  r_rsp_status;
    logic [7:0]  r_rsp_rdata;
    logic [7:0]  w_step_data;
    logic [2:0]  w_last_step;
    logic [2:0]  w_step_inc;

    // CTRL = {CR2, ENS1, STA, STO, SI, AA, CR1, CR0}; SI written 0 clears INT.
    function automatic logic [7:0] f_ctrl(input logic sta, input logic sto);
        return {CR_BITS[2], 1'b1, sta, sto, 1'b0, 1'b0, CR_BITS[1:0]};
    endfunction

    function automatic logic f_sta(input logic rd, input logic [2:0] step);
        return (step == 3'd0) || (rd && step == 3'd3);
    endfunction

    function automatic logic f_has_data(input logic rd, input logic [2:0] step);
        return (step == 3'd1) || (step == 3'd2) ||
               (!rd && step == 3'd3) || (rd && step == 3'd4);
    endfunction

    function automatic logic [7:0] f_expect(input logic rd, input logic [2:0] step);
        case (step)
            3'd0:    return 8'h08;
            3'd1:    return 8'h18;
            3'd2:    return 8'h28;
            3'd3:    return rd ? 8'h10 : 8'h28;
            3'd4:    return 8'h40;
            default: return 8'h58;
        endcase
    endfunction

    assign w_last_step = r_rd ? 3'd5 : 3'd3;
    assign w_step_inc  = r_step + 3'd1;

    always_comb begin
        w_step_data = 8'h00;
        case (r_step)
            3'd1:    w_step_data = {r_dev, 1'b0};
            3'd2:    w_step_data = r_reg;
            3'd3:    w_step_data = r_wdata;
            3'd4:    w_step_data = {r_dev, 1'b1};
            default: w_step_data = 8'h00;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state      <= S_IDLE;
            r_op         <= OP_CTRL;
            r_step       <= 3'd0;
            r_cnt        <= 16'd0;
            r_err        <= 1'b0;
            r_status     <= 8'h00;
            r_rdata      <= 8'h00;
            r_rd         <= 1'b0;
            r_dev        <= 7'h00;
            r_reg        <= 8'h00;
            r_wdata      <= 8'h00;
            r_rsp_err    <= 1'b0;
            r_rsp_status <= 8'h00;
            r_rsp_rdata  <= 8'h00;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_step   <= w_step_nxt;
            r_cnt    <= w_cnt_nxt;
            r_err    <= w_err_nxt;
            r_status <= w_status_nxt;
            r_rdata  <= w_rdata_nxt;
            if (w_load_cmd) begin
                r_rd         <= cmd_rd;
                r_dev        <= cmd_dev;
                r_reg        <= cmd_reg;
                r_wdata      <= cmd_wdata;
                r_rsp_err    <= 1'b0;
                r_rsp_status <= 8'h00;
                r_rsp_rdata  <= 8'h00;
            end else if (w_state_nxt == S_DONE) begin
                // Response is captured on entry so it is valid alongside the strobe.
                r_rsp_err    <= r_err;
                r_rsp_status <= r_status;
                r_rsp_rdata  <= r_rdata;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_step_nxt   = r_step;
        w_cnt_nxt    = r_cnt;
        w_err_nxt    = r_err;
        w_status_nxt = r_status;
        w_rdata_nxt  = r_rdata;
        w_load_cmd   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_load_cmd   = 1'b1;
                    w_step_nxt   = 3'd0;
                    w_op_nxt     = OP_CTRL;
                    w_err_nxt    = 1'b0;
                    w_status_nxt = 8'h00;
                    w_rdata_nxt  = 8'h00;
                    w_state_nxt  = S_APB_SETUP;
                end
            end
            S_APB_SETUP: w_state_nxt = S_APB_ACCESS;
            S_APB_ACCESS: begin
                case (r_op)
                    OP_DATA: begin
                        w_op_nxt    = OP_CTRL;
                        w_state_nxt = S_GAP;
                    end
                    OP_CTRL: begin
                        w_cnt_nxt   = 16'd0;
                        w_state_nxt = S_WAIT_INT;
                    end
                    OP_STATUS: begin
                        w_status_nxt = PRDATA;
                        w_state_nxt  = S_CHECK;
                    end
                    OP_RDATA: begin
                        w_rdata_nxt = PRDATA;
                        w_op_nxt    = OP_STOP;
                        w_state_nxt = S_GAP;
                    end
                    default: w_state_nxt = S_DONE;
                endcase
            end
            S_GAP: w_state_nxt = S_APB_SETUP;
            S_WAIT_INT: begin
                if (INT) begin
                    w_op_nxt    = OP_STATUS;
                    w_state_nxt = S_APB_SETUP;
                end else if (r_cnt == c_TO_LAST) begin
                    w_status_nxt = c_ST_TIMEOUT;
                    w_state_nxt  = S_ABORT;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_CHECK: begin
                // The idle CHECK cycle doubles as the inter-transfer gap.
                if (r_status != f_expect(r_rd, r_step)) begin
                    w_state_nxt = S_ABORT;
                end else if (r_step == w_last_step) begin
                    w_op_nxt    = r_rd ? OP_RDATA : OP_STOP;
                    w_state_nxt = S_APB_SETUP;
                end else begin
                    w_step_nxt  = w_step_inc;
                    w_op_nxt    = f_has_data(r_rd, w_step_inc) ? OP_DATA : OP_CTRL;
                    w_state_nxt = S_APB_SETUP;
                end
            end
            S_ABORT: begin
                w_err_nxt   = 1'b1;
                w_op_nxt    = OP_STOP;
                w_state_nxt = S_APB_SETUP;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 9'h000;
        PWDATA  = 8'h00;
        if (r_state == S_APB_SETUP || r_state == S_APB_ACCESS) begin
            PSEL    = 1'b1;
            PENABLE = (r_state == S_APB_ACCESS);
            case (r_op)
                OP_DATA: begin
                    PWRITE = 1'b1;
                    PADDR  = {c_CHAN, c_ADDR_DATA};
                    PWDATA = w_step_data;
                end
                OP_CTRL: begin
                    PWRITE = 1'b1;
                    PADDR  = {c_CHAN, c_ADDR_CTRL};
                    PWDATA = f_ctrl(f_sta(r_rd, r_step), 1'b0);
                end
                OP_STATUS: PADDR = {c_CHAN, c_ADDR_STAT};
                OP_RDATA:  PADDR = {c_CHAN, c_ADDR_DATA};
                default: begin
                    PWRITE = 1'b1;
                    PADDR  = {c_CHAN, c_ADDR_CTRL};
                    PWDATA = f_ctrl(1'b0, 1'b1);
                end
            endcase
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign rsp_valid  = (r_state == S_DONE);
    assign rsp_err    = r_rsp_err;
    assign rsp_status = r_rsp_status;
    assign rsp_rdata  = r_rsp_rdata;

endmodule
`default_nettype wire
